// File: rtl/util_regslice_hs_pkg.sv
// Shared constants for the handshake register slice: stage mode encodings
// and an elaboration-time mode check.
package util_regslice_hs_pkg;

    localparam int REGSLICE_MODE_FULL = 0;
    localparam int REGSLICE_MODE_FWD  = 1;

    function automatic bit regslice_mode_ok(input int mode);
        return (mode == REGSLICE_MODE_FULL) || (mode == REGSLICE_MODE_FWD);
    endfunction

endpackage

// File: rtl/util_regslice_hs_if.sv
// Valid/ready streaming bundle; master drives data/valid, slave drives ready.
interface util_regslice_hs_if #(
    parameter int C_WIDTH = 32
) ();
    logic [C_WIDTH-1:0] data;
    logic               valid;
    logic               ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/util_regslice_hs_stage.sv
// One register-slice stage: full mode is a two-entry skid buffer with a
// registered ready; forward mode registers data/valid and passes ready through.
module util_regslice_hs_stage
    import util_regslice_hs_pkg::*;
#(
    parameter int C_WIDTH = 32,
    parameter int C_MODE  = REGSLICE_MODE_FULL
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [C_WIDTH-1:0] s_data_i,
    input  logic               s_valid_i,
    output logic               s_ready_o,
    output logic [C_WIDTH-1:0] m_data_o,
    output logic               m_valid_o,
    input  logic               m_ready_i
);

    logic               mv_q, mv_d;
    logic [C_WIDTH-1:0] md_q, md_d;
    logic               accept;

    generate
        if (C_MODE == REGSLICE_MODE_FULL) begin : g_full
            logic               kv_q, kv_d;
            logic [C_WIDTH-1:0] kd_q, kd_d;
            logic               rdy_q;

            assign accept    = s_valid_i && rdy_q;
            assign s_ready_o = rdy_q;

            // A beat only lands in the skid when main is stuck; skid is drained first.
            always_comb begin
                mv_d = mv_q;
                md_d = md_q;
                kv_d = kv_q;
                kd_d = kd_q;
                if (kv_q) begin
                    if (m_ready_i) begin
                        mv_d = 1'b1;
                        md_d = kd_q;
                        kv_d = 1'b0;
                    end
                end else if (accept) begin
                    if (mv_q && !m_ready_i) begin
                        kv_d = 1'b1;
                        kd_d = s_data_i;
                    end else begin
                        mv_d = 1'b1;
                        md_d = s_data_i;
                    end
                end else if (m_ready_i) begin
                    mv_d = 1'b0;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    kv_q  <= 1'b0;
                    kd_q  <= '0;
                    rdy_q <= 1'b0;
                end else begin
                    kv_q  <= kv_d;
                    kd_q  <= kd_d;
                    rdy_q <= !kv_d;
                end
            end
        end else begin : g_fwd
            assign s_ready_o = !mv_q || m_ready_i;
            assign accept    = s_valid_i && s_ready_o;

            always_comb begin
                mv_d = mv_q;
                md_d = md_q;
                if (accept) begin
                    mv_d = 1'b1;
                    md_d = s_data_i;
                end else if (m_ready_i) begin
                    mv_d = 1'b0;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mv_q <= 1'b0;
            md_q <= '0;
        end else begin
            mv_q <= mv_d;
            md_q <= md_d;
        end
    end

    assign m_valid_o = mv_q;
    assign m_data_o  = md_q;

endmodule

// File: rtl/util_regslice_hs.sv
// Chain of C_NUM_STAGES handshake register stages; zero stages degenerates
// to a wire-through of the stream.
module util_regslice_hs
    import util_regslice_hs_pkg::*;
#(
    parameter int C_WIDTH      = 32,
    parameter int C_NUM_STAGES = 2,
    parameter int C_MODE       = REGSLICE_MODE_FULL
) (
    input  logic                   clk,
    input  logic                   rst_n,
    util_regslice_hs_if.slave      s,
    util_regslice_hs_if.master     m
);

    generate
        if (!regslice_mode_ok(C_MODE)) begin : g_bad_mode
            $error("util_regslice_hs: illegal C_MODE %0d", C_MODE);
        end
        if (C_NUM_STAGES < 0) begin : g_bad_stages
            $error("util_regslice_hs: negative C_NUM_STAGES %0d", C_NUM_STAGES);
        end

        if (C_NUM_STAGES == 0) begin : g_bypass
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst_n;
            assign m.data  = s.data;
            assign m.valid = s.valid;
            assign s.ready = m.ready;
        end else if (C_NUM_STAGES > 0) begin : g_chain
            // Index i is the boundary in front of stage i; index C_NUM_STAGES is m.
            logic [C_NUM_STAGES:0][C_WIDTH-1:0] data_w;
            logic [C_NUM_STAGES:0]              valid_w;
            logic [C_NUM_STAGES:0]              ready_w;

            assign data_w[0]            = s.data;
            assign valid_w[0]           = s.valid;
            assign s.ready              = ready_w[0];
            assign m.data               = data_w[C_NUM_STAGES];
            assign m.valid              = valid_w[C_NUM_STAGES];
            assign ready_w[C_NUM_STAGES] = m.ready;

            for (genvar i = 0; i < C_NUM_STAGES; i++) begin : g_stage
                util_regslice_hs_stage #(
                    .C_WIDTH (C_WIDTH),
                    .C_MODE  (C_MODE)
                ) u_stage (
                    .clk       (clk),
                    .rst_n     (rst_n),
                    .s_data_i  (data_w[i]),
                    .s_valid_i (valid_w[i]),
                    .s_ready_o (ready_w[i]),
                    .m_data_o  (data_w[i+1]),
                    .m_valid_o (valid_w[i+1]),
                    .m_ready_i (ready_w[i+1])
                );
            end
        end
    endgenerate

endmodule

// File: tb/tb_util_regslice_hs.sv
// Bench for util_regslice_hs: full/2, forward/3, bypass/0 and full/1 instances
// checked against a beat-count and queue model of the stream.
module tb_util_regslice_hs;
    import util_regslice_hs_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    util_regslice_hs_if #(.C_WIDTH(32)) s0 (), m0 (), s1 (), m1 (), s2 (), m2 (), s3 (), m3 ();

    util_regslice_hs #(.C_WIDTH(32), .C_NUM_STAGES(2), .C_MODE(REGSLICE_MODE_FULL))
        u_full2 (.clk(clk), .rst_n(rst_n), .s(s0.slave), .m(m0.master));
    util_regslice_hs #(.C_WIDTH(32), .C_NUM_STAGES(3), .C_MODE(REGSLICE_MODE_FWD))
        u_fwd3  (.clk(clk), .rst_n(rst_n), .s(s1.slave), .m(m1.master));
    util_regslice_hs #(.C_WIDTH(32), .C_NUM_STAGES(0), .C_MODE(REGSLICE_MODE_FULL))
        u_byp   (.clk(clk), .rst_n(rst_n), .s(s2.slave), .m(m2.master));
    util_regslice_hs #(.C_WIDTH(32), .C_NUM_STAGES(1), .C_MODE(REGSLICE_MODE_FULL))
        u_full1 (.clk(clk), .rst_n(rst_n), .s(s3.slave), .m(m3.master));

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        s0.valid = 0; s0.data = '0; m0.ready = 1;
        s1.valid = 0; s1.data = '0; m1.ready = 0;
        s2.valid = 0; s2.data = '0; m2.ready = 0;
        s3.valid = 0; s3.data = '0; m3.ready = 0;
        #1 rst_n = 1'b0;
        #11;
        checks++; if (m0.valid !== 1'b0) $display("FAIL reset_full_mvalid: got %b expected 0", m0.valid);
        if (m0.valid !== 1'b0) errors++;
        checks++; if (m0.data !== 32'h0) begin errors++; $display("FAIL reset_full_mdata: got %h expected 0", m0.data); end
        checks++; if (s0.ready !== 1'b0) begin errors++; $display("FAIL reset_full_sready: got %b expected 0", s0.ready); end
        checks++; if (m1.valid !== 1'b0) begin errors++; $display("FAIL reset_fwd_mvalid: got %b expected 0", m1.valid); end
        checks++; if (m1.data !== 32'h0) begin errors++; $display("FAIL reset_fwd_mdata: got %h expected 0", m1.data); end
        #10 rst_n = 1'b1;  // released mid-cycle, between edges
        #1;
        checks++; if (s0.ready !== 1'b0) begin errors++; $display("FAIL reset_full_sready_pre_edge: got %b expected 0", s0.ready); end
        checks++; if (s1.ready !== 1'b1) begin errors++; $display("FAIL reset_fwd_sready: got %b expected 1", s1.ready); end
        next_cycle();
        checks++; if (s0.ready !== 1'b1) begin errors++; $display("FAIL reset_full_sready_post_edge: got %b expected 1", s0.ready); end
        checks++; if (s3.ready !== 1'b1) begin errors++; $display("FAIL reset_full1_sready_post_edge: got %b expected 1", s3.ready); end
    endtask

    task automatic test_streaming();
        int  vcnt = 0;
        bit  exp_v;
        for (int c = 0; c < 20; c++) begin
            s0.valid = (c < 16);
            s0.data  = 32'(c + 1);
            m0.ready = 1'b1;
            @(negedge clk);
            checks++; if (s0.ready !== 1'b1) begin errors++; $display("FAIL stream_sready c=%0d: got %b expected 1", c, s0.ready); end
            exp_v = (c >= 2 && c < 18);
            checks++; if (m0.valid !== exp_v) begin errors++; $display("FAIL stream_mvalid c=%0d: got %b expected %b", c, m0.valid, exp_v); end
            if (exp_v) begin
                checks++; if (m0.data !== 32'(c - 1)) begin errors++; $display("FAIL stream_mdata c=%0d: got %h expected %h", c, m0.data, 32'(c - 1)); end
            end
            if (m0.valid === 1'b1) vcnt++;
            next_cycle();
        end
        s0.valid = 1'b0;
        checks++; if (vcnt != 16) begin errors++; $display("FAIL stream_vcount: got %0d expected 16", vcnt); end
    endtask

    task automatic test_backpressure();
        logic [31:0] sb[$];
        logic [31:0] nxt = 32'h100;
        logic [31:0] exp;
        int sent = 0, rcvd = 0, first_low = -1;
        bit s_f, m_f;
        for (int c = 0; c < 40; c++) begin
            s0.valid = (c < 28);
            s0.data  = nxt;
            m0.ready = !(c >= 6 && c < 12);
            @(negedge clk);
            if (c >= 6 && c < 12 && s0.ready === 1'b0 && first_low < 0) first_low = c - 6;
            if (c == 11) begin
                checks++; if (sb.size() != 4) begin errors++; $display("FAIL bp_buffered: got %0d expected 4", sb.size()); end
                checks++; if (s0.ready !== 1'b0) begin errors++; $display("FAIL bp_sready_full: got %b expected 0", s0.ready); end
            end
            s_f = s0.valid && s0.ready;
            m_f = m0.valid && m0.ready;
            if (m_f) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++; $display("FAIL bp_spurious: got beat %h expected none", m0.data);
                end else begin
                    exp = sb.pop_front();
                    if (m0.data !== exp) begin errors++; $display("FAIL bp_order: got %h expected %h", m0.data, exp); end
                end
                rcvd++;
            end
            if (s_f) begin sb.push_back(nxt); nxt++; sent++; end
            next_cycle();
        end
        s0.valid = 1'b0;
        checks++; if (first_low < 0 || first_low > 2) begin errors++; $display("FAIL bp_sready_drop: got offset %0d expected 0..2", first_low); end
        checks++; if (rcvd != sent || sb.size() != 0) begin errors++; $display("FAIL bp_count: got %0d received expected %0d", rcvd, sent); end
    endtask

    task automatic test_random_stall();
        logic [31:0] sb[$];
        logic [31:0] exp;
        int  sent = 0, rcvd = 0, cyc = 0;
        bit  hold = 0, exp_rdy, s_f, m_f;
        s1.valid = 1'b0;
        while (rcvd < 1000 && cyc < 20000) begin
            if (!hold) begin
                s1.valid = (sent < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
                s1.data  = $urandom;
            end
            m1.ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            exp_rdy = m1.ready || (sb.size() < 3);
            checks++; if (s1.ready !== exp_rdy) begin errors++; $display("FAIL rnd_sready cyc=%0d: got %b expected %b", cyc, s1.ready, exp_rdy); end
            s_f  = s1.valid && s1.ready;
            m_f  = m1.valid && m1.ready;
            hold = s1.valid && !s1.ready;
            if (m_f) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++; $display("FAIL rnd_spurious: got beat %h expected none", m1.data);
                end else begin
                    exp = sb.pop_front();
                    if (m1.data !== exp) begin errors++; $display("FAIL rnd_order: got %h expected %h", m1.data, exp); end
                end
                rcvd++;
            end
            if (s_f) begin sb.push_back(s1.data); sent++; end
            cyc++;
            next_cycle();
        end
        s1.valid = 1'b0;
        m1.ready = 1'b0;
        checks++; if (rcvd != 1000) begin errors++; $display("FAIL rnd_timeout: got %0d beats expected 1000", rcvd); end
    endtask

    task automatic test_reset_mid();
        int acc = 0;
        m0.ready = 1'b0;
        for (int i = 0; i < 10 && acc < 4; i++) begin
            s0.valid = 1'b1;
            s0.data  = 32'hA0 + 32'(acc);
            @(negedge clk);
            if (s0.ready === 1'b1) acc++;
            next_cycle();
        end
        s0.valid = 1'b0;
        checks++; if (acc != 4) begin errors++; $display("FAIL rst_fill: got %0d expected 4", acc); end
        @(negedge clk);
        checks++; if (m0.valid !== 1'b1 || s0.ready !== 1'b0) begin errors++; $display("FAIL rst_full_state: got v=%b r=%b expected v=1 r=0", m0.valid, s0.ready); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (m0.valid !== 1'b0) begin errors++; $display("FAIL rst_mid_mvalid: got %b expected 0", m0.valid); end
        checks++; if (m0.data !== 32'h0) begin errors++; $display("FAIL rst_mid_mdata: got %h expected 0", m0.data); end
        checks++; if (s0.ready !== 1'b0) begin errors++; $display("FAIL rst_mid_sready: got %b expected 0", s0.ready); end
        next_cycle();
        checks++; if (s0.ready !== 1'b0) begin errors++; $display("FAIL rst_hold_sready: got %b expected 0", s0.ready); end
        #2 rst_n = 1'b1;
        #1;
        checks++; if (s0.ready !== 1'b0) begin errors++; $display("FAIL rst_rel_sready: got %b expected 0", s0.ready); end
        next_cycle();
        checks++; if (s0.ready !== 1'b1) begin errors++; $display("FAIL rst_edge_sready: got %b expected 1", s0.ready); end
        m0.ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++; if (m0.valid !== 1'b0) begin errors++; $display("FAIL rst_stale c=%0d: got %b expected 0", c, m0.valid); end
            next_cycle();
        end
    endtask

    task automatic test_bypass();
        bit v, r;
        logic [31:0] d;
        s2.data = 32'hDEADBEEF; s2.valid = 1'b1; m2.ready = 1'b0;
        #1;
        checks++; if (m2.data !== 32'hDEADBEEF || m2.valid !== 1'b1) begin errors++; $display("FAIL byp_fwd: got %h/%b expected deadbeef/1", m2.data, m2.valid); end
        checks++; if (s2.ready !== 1'b0) begin errors++; $display("FAIL byp_ready0: got %b expected 0", s2.ready); end
        m2.ready = 1'b1;
        #1;
        checks++; if (s2.ready !== 1'b1) begin errors++; $display("FAIL byp_ready1: got %b expected 1", s2.ready); end
        for (int k = 0; k < 4; k++) begin
            d = $urandom; v = 1'($urandom_range(0, 1)); r = 1'($urandom_range(0, 1));
            s2.data = d; s2.valid = v; m2.ready = r;
            #1;
            checks++; if (m2.data !== d || m2.valid !== v || s2.ready !== r) begin
                errors++; $display("FAIL byp_rand k=%0d: got %h/%b/%b expected %h/%b/%b", k, m2.data, m2.valid, s2.ready, d, v, r);
            end
        end
        s2.valid = 1'b0; m2.ready = 1'b0;
        next_cycle();
    endtask

    task automatic test_simul_accept_emit();
        logic [31:0] a = $urandom, b = $urandom;
        s3.valid = 1'b1; s3.data = a; m3.ready = 1'b0;
        @(negedge clk);
        checks++; if (s3.ready !== 1'b1 || m3.valid !== 1'b0) begin errors++; $display("FAIL sim_idle: got r=%b v=%b expected r=1 v=0", s3.ready, m3.valid); end
        next_cycle();
        s3.data = b; m3.ready = 1'b1;
        @(negedge clk);
        checks++; if (m3.valid !== 1'b1 || m3.data !== a) begin errors++; $display("FAIL sim_hold_a: got %h/%b expected %h/1", m3.data, m3.valid, a); end
        next_cycle();
        s3.valid = 1'b0; m3.ready = 1'b0;
        @(negedge clk);
        checks++; if (m3.valid !== 1'b1 || m3.data !== b) begin errors++; $display("FAIL sim_shift_b: got %h/%b expected %h/1", m3.data, m3.valid, b); end
        checks++; if (s3.ready !== 1'b1) begin errors++; $display("FAIL sim_skid_empty: got %b expected 1", s3.ready); end
        next_cycle();
        @(negedge clk);
        checks++; if (s3.ready !== 1'b1 || m3.valid !== 1'b1) begin errors++; $display("FAIL sim_occ1: got r=%b v=%b expected r=1 v=1", s3.ready, m3.valid); end
        next_cycle();
        m3.ready = 1'b1;
        next_cycle();
        @(negedge clk);
        checks++; if (m3.valid !== 1'b0) begin errors++; $display("FAIL sim_drain: got %b expected 0", m3.valid); end
        next_cycle();
        m3.ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_random_stall();
        test_reset_mid();
        test_bypass();
        test_simul_accept_emit();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
